// File: rtl/rtc_display_scan.sv
// rtc_display_scan: six-digit multiplexed 7-segment scanner for the stopwatch
// counter chain (mm.ss.cc). A snapshot register can be frozen by the lap
// button, and every digit slot starts with a short all-anodes-off gap.
//
// Optional feature: define RTC_DISP_LZB_EN to blank leading zeros of the
// minutes field (evaluated on the snapshot).

module rtc_display_scan #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BLANK    = 2
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic [3:0] ml,
    input  logic [3:0] mh,
    input  logic [3:0] sl,
    input  logic [3:0] sh,
    input  logic [3:0] msl,
    input  logic [3:0] msh,
    input  logic       hold,
    output logic       frozen,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);

    localparam logic [5:0] AN_OFF  = 6'h3F;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Segment patterns {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] decode7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;  // non-BCD shown as a dash
        endcase
        return s;
    endfunction

    logic [PCNT_W-1:0] pcntQ, pcntD;
    logic [2:0]        idxQ, idxD;
    logic              holdQ;
    logic              frozenQ, frozenD;
    logic [23:0]       snapQ, snapD;
    logic              lastTick;
    logic              holdRise;
    logic              blankNow;
    logic [3:0]        digit;
    logic [5:0]        anD;
    logic [6:0]        segD;
    logic              dpD;

    assign frozen = frozenQ;

    // Next-state for snapshot/freeze and the scan counters.
    always_comb begin
        holdRise = hold & ~holdQ;
        frozenD  = frozenQ ^ holdRise;
        // Load decision uses the pre-toggle freeze state, so a lap edge
        // captures the inputs of the very cycle it is detected in.
        snapD    = frozenQ ? snapQ : {mh, ml, sh, sl, msh, msl};
        lastTick = (pcntQ == PCNT_LAST);
        pcntD    = lastTick ? '0 : pcntQ + PCNT_W'(1);
        idxD     = idxQ;
        if (lastTick) begin
            idxD = (idxQ == 3'd5) ? 3'd0 : idxQ + 3'd1;
        end
    end

    // Blank gap at the start of each slot; a zero-length gap needs no compare.
    generate
        if (BLANK == 0) begin : gNoBlank
            assign blankNow = 1'b0;
        end else begin : gBlank
            assign blankNow = (pcntQ < PCNT_W'(BLANK));
        end
    endgenerate

    // Select the snapshot nibble for the current digit slot.
    always_comb begin
        digit = snapQ[3:0];
        case (idxQ)
            3'd0:    digit = snapQ[3:0];
            3'd1:    digit = snapQ[7:4];
            3'd2:    digit = snapQ[11:8];
            3'd3:    digit = snapQ[15:12];
            3'd4:    digit = snapQ[19:16];
            3'd5:    digit = snapQ[23:20];
            default: digit = snapQ[3:0];
        endcase
    end

    // Output-stage next values: dark during the gap, else the decoded digit.
    always_comb begin
        anD  = AN_OFF;
        segD = SEG_OFF;
        dpD  = 1'b1;
        if (!blankNow) begin
            anD  = ~(6'b000001 << idxQ);
            segD = decode7(digit);
            // Points after minutes and seconds: mm.ss.cc
            dpD  = !((idxQ == 3'd2) || (idxQ == 3'd4));
`ifdef RTC_DISP_LZB_EN
            if ((idxQ == 3'd5) && (snapQ[23:20] == 4'd0)) begin
                segD = SEG_OFF;
            end
            if ((idxQ == 3'd4) && (snapQ[23:20] == 4'd0) && (snapQ[19:16] == 4'd0)) begin
                segD = SEG_OFF;
                dpD  = 1'b1;
            end
`endif
        end
    end

    // State and registered outputs; aclr clears everything immediately.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            pcntQ   <= '0;
            idxQ    <= 3'd0;
            holdQ   <= 1'b0;
            frozenQ <= 1'b0;
            snapQ   <= 24'd0;
            an      <= AN_OFF;
            seg     <= SEG_OFF;
            dp      <= 1'b1;
        end else begin
            pcntQ   <= pcntD;
            idxQ    <= idxD;
            holdQ   <= hold;
            frozenQ <= frozenD;
            snapQ   <= snapD;
            an      <= anD;
            seg     <= segD;
            dp      <= dpD;
        end
    end

endmodule

// File: tb/tb_rtc_display_scan.sv
// Self-checking bench for rtc_display_scan (SCAN_DIV=4, BLANK=1). A cycle-count
// reference model predicts every output from elapsed cycles and a digit array.

module tb_rtc_display_scan;

    localparam int unsigned SD = 4;
    localparam int unsigned BL = 1;

    logic       clk = 1'b0;
    logic       aclr;
    logic [3:0] ml, mh, sl, sh, msl, msh;
    logic       hold;
    logic       frozen;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Model state: digits indexed by scan position (0 = msl .. 5 = mh).
    logic [3:0]  inD   [6];
    logic [3:0]  snapM [6];
    logic        frozenM;
    logic        holdIn;
    logic        holdPrev;
    int unsigned cyc;

    always #5 clk = ~clk;

    rtc_display_scan #(
        .SCAN_DIV(SD),
        .BLANK   (BL)
    ) dut (
        .clk   (clk),
        .aclr  (aclr),
        .ml    (ml),
        .mh    (mh),
        .sl    (sl),
        .sh    (sh),
        .msl   (msl),
        .msh   (msh),
        .hold  (hold),
        .frozen(frozen),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    function automatic logic [6:0] segOf(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic modelReset();
        cyc      = 0;
        frozenM  = 1'b0;
        holdPrev = 1'b0;
        for (int k = 0; k < 6; k++) snapM[k] = 4'd0;
    endtask

    // One clock: drive inputs, predict outputs from the pre-edge model, compare.
    task automatic step();
        logic [5:0] eAn;
        logic [6:0] eSeg;
        logic       eDp;
        int         i;
        {mh, ml, sh, sl, msh, msl} = {inD[5], inD[4], inD[3], inD[2], inD[1], inD[0]};
        hold = holdIn;
        if ((cyc % SD) < BL) begin
            eAn  = 6'h3F;
            eSeg = 7'h7F;
            eDp  = 1'b1;
        end else begin
            i    = int'((cyc / SD) % 6);
            eAn  = ~(6'd1 << i);
            eSeg = segOf(snapM[i]);
            eDp  = !(i == 2 || i == 4);
`ifdef RTC_DISP_LZB_EN
            if (i == 5 && snapM[5] == 4'd0) eSeg = 7'h7F;
            if (i == 4 && snapM[5] == 4'd0 && snapM[4] == 4'd0) begin
                eSeg = 7'h7F;
                eDp  = 1'b1;
            end
`endif
        end
        @(posedge clk);
        #1;
        if (!frozenM) begin
            for (int k = 0; k < 6; k++) snapM[k] = inD[k];
        end
        if (holdIn && !holdPrev) frozenM = !frozenM;
        holdPrev = holdIn;
        cyc++;
        chk("an", 32'(an), 32'(eAn));
        chk("seg", 32'(seg), 32'(eSeg));
        chk("dp", 32'(dp), 32'(eDp));
        chk("frozen", 32'(frozen), 32'(frozenM));
    endtask

    // Pulse aclr between edges and confirm the asynchronous clear.
    task automatic pulseReset(input string tag);
        #2 aclr = 1'b1;
        #1;
        chk({tag, "_an"}, 32'(an), 32'h3F);
        chk({tag, "_seg"}, 32'(seg), 32'h7F);
        chk({tag, "_dp"}, 32'(dp), 32'h1);
        chk({tag, "_frozen"}, 32'(frozen), 32'h0);
        #1 aclr = 1'b0;
        modelReset();
    endtask

    initial begin
        int guard;
        aclr   = 1'b1;
        holdIn = 1'b0;
        hold   = 1'b0;
        // mh..msl = 1,2,3,4,5,6
        for (int k = 0; k < 6; k++) inD[k] = 4'(6 - k);
        {mh, ml, sh, sl, msh, msl} = {inD[5], inD[4], inD[3], inD[2], inD[1], inD[0]};
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        pulseReset("reset");

        // Scan order and frame wrap (more than one full frame).
        for (int n = 0; n < 30; n++) step();

        // Decode: every value 0..15 on every digit position.
        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < 6; k++) inD[k] = 4'(v);
            for (int n = 0; n < 24; n++) step();
        end

        // Lap freeze: ramp msl, pulse hold at msl=7, then release at a second pulse.
        for (int k = 0; k < 6; k++) inD[k] = 4'd0;
        for (int n = 0; n < 60; n++) begin
            inD[0] = 4'(n % 10);
            holdIn = (n == 7) || (n == 40);
            step();
            if (n == 7) chk("lap_frozen", 32'(frozen), 32'h1);
            if (n == 40) chk("lap_release", 32'(frozen), 32'h0);
        end
        holdIn = 1'b0;

        // Long hold: exactly one toggle.
        holdIn = 1'b1;
        for (int n = 0; n < 100; n++) step();
        holdIn = 1'b0;
        step();
        chk("long_hold", 32'(frozen), 32'h1);
        holdIn = 1'b1;
        step();
        holdIn = 1'b0;
        step();

        // Random digits and occasional lap presses.
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 6; k++) inD[k] = 4'($urandom_range(0, 15));
            holdIn = ($urandom_range(0, 19) == 0);
            step();
        end
        holdIn = 1'b0;
        step();

        // Freeze, run to mid-slot of idx 3, then reset between edges.
        if (!frozenM) begin
            holdIn = 1'b1;
            step();
            holdIn = 1'b0;
        end
        guard = 0;
        while ((((cyc / SD) % 6) != 3 || (cyc % SD) != 2) && guard < 60) begin
            step();
            guard++;
        end
        chk("reach_idx3", 32'(guard < 60), 32'h1);
        chk("pre_reset_frozen", 32'(frozen), 32'h1);
        pulseReset("midreset");
        for (int n = 0; n < 30; n++) step();

        // Leading-zero cases on the minutes field.
        for (int k = 0; k < 4; k++) inD[k] = 4'd5;
        inD[5] = 4'd0;
        inD[4] = 4'd0;
        for (int n = 0; n < 30; n++) step();
        inD[4] = 4'd3;
        for (int n = 0; n < 30; n++) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rtc_display_scan.md
# rtc_display_scan

Multiplexed 7-segment scanner that consumes the six BCD digits produced by the real-time stopwatch counter chain (minutes, seconds, hundredths) and drives a six-digit common-anode display, one digit at a time.
- Holds a snapshot register that a user "hold" button can freeze for lap display while the counters keep running.
- Inserts a short anode-off blanking gap at every digit change to suppress ghosting.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles each digit is selected; legal range SCAN_DIV ≥ BLANK+2.
- BLANK, 2: clk cycles at the start of each digit slot with all anodes off; 0 disables the gap.

Ports:
- clk  in  1  system clock; all state on rising edge.
- aclr  in  1  asynchronous, active-high reset.
- ml, mh, sl, sh, msl, msh  in  4 each  BCD digits: minutes low/high, seconds low/high, hundredths low/high.
- hold  in  1  lap button, already debounced and synchronous to clk; each rising edge toggles freeze.
- frozen  out  1  1 = snapshot held, 0 = snapshot tracking inputs.
- an  out  6  anode selects, active-low, one-hot or all-high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
Snapshot:
- 24-bit register, ordered {mh,ml,sh,sl,msh,msl}.
- When frozen=0 it loads the inputs every clk. When frozen=1 it holds.
- hold_q is hold registered once. A rising edge is hold & ~hold_q; on that cycle frozen toggles.
- The load in the edge cycle uses the old frozen value, so the captured value is the inputs of the cycle in which the edge is detected.

Scan:
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps.
- At pcnt==SCAN_DIV-1, digit index idx advances 0→1→…→5→0.
- idx mapping: 0 msl, 1 msh, 2 sl, 3 sh, 4 ml, 5 mh. an[i] selects idx i.

Output stage (registered):
- If pcnt < BLANK: an = 6'h3F, seg = 7'h7F, dp = 1.
- Otherwise: an = ~(1<<idx), seg = decode(snapshot digit idx), dp = 0 for idx 2 and 4 only (display reads mm.ss.cc), else 1.

Decode:
- 0–9: standard patterns, e.g. 0 → 7'b1000000, 8 → 7'b0000000.
- 10–15: dash (g only) → 7'b0111111.

## Timing
- Reset (aclr=1, effective immediately and held while asserted): pcnt=0, idx=0, frozen=0, hold_q=0, snapshot=0, an=6'h3F, seg=7'h7F, dp=1.
- Latency: an/seg/dp reflect pcnt/idx/snapshot of the previous clk, i.e. 1 cycle.
- With BLANK=0, the first digit appears on the 1st edge after reset release. Otherwise it appears on the edge after pcnt reaches BLANK.
- Input change to display: 2 clks (snapshot load + output register), if that digit is currently selected and not blanked.
- Each digit slot is exactly SCAN_DIV cycles: BLANK cycles dark, then SCAN_DIV−BLANK lit. Full frame is 6·SCAN_DIV cycles.
- idx wraps 5→0 with no extra cycle.
- hold held high for many cycles produces exactly one toggle. A hold edge during a blank gap acts identically.
- Reset mid-frame aborts the scan and clears freeze. The frame restarts at idx 0 after release.

## Configuration
- RTC_DISP_LZB_EN defined: leading-zero blanking, evaluated on the snapshot.
  - snapshot mh==0 → digit 5 seg = 7'h7F.
  - mh==0 and ml==0 → digit 4 seg = 7'h7F and its dp = 1.
  - Anodes still scan normally.
- Macro undefined: all six digits always decoded; zeros shown as "0".

## Test plan
- Reset/scan, SCAN_DIV=4, BLANK=1, inputs {1,2,3,4,5,6} (mh..msl):
  - After reset release, an sequences 3F, 3E, 3E, 3E (digit 6), 3F, 3D, 3D, 3D (digit 5) … through 1F (digit 1).
  - Frame wraps to 3E at cycle 24.
  - dp = 0 only while an = 3B or 2F.
- Decode: drive msl=0..15 while idx 0 is lit → seg matches the 0–9 table, then 7'b0111111 for 10–15.
- Freeze: ramp msl every cycle, pulse hold for 1 cycle at msl=7 → frozen=1, digit 0 shows 7 while msl keeps changing. Second hold pulse → frozen=0, display tracks again within 2 clks.
- Long hold: hold high for 100 cycles → frozen toggles once, to 1.
- Async reset while frozen mid-slot (idx 3): aclr pulse asserted between edges → an=3F and frozen=0 before the next edge. Scan restarts at idx 0.
- RTC_DISP_LZB_EN defined:
  - mh=0, ml=0 → digits 5 and 4 dark, dp of digit 4 = 1.
  - mh=0, ml=3 → only digit 5 dark.
  - Macro undefined → both show 7'b1000000.
